// File: rtl/click_to_sync_bridge.sv
// Click (2-phase bundled-data) receiver: synchronises req, captures data into a
// small FWFT FIFO, returns ack from a flop and presents tokens as valid/ready.
module click_to_sync_bridge #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_req,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ack,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [SYNC_STAGES-1:0]         sync_q, sync_d;
    logic                           ack_q, ack_d;
    logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [DATA_W-1:0]              hold_q, hold_d;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_q, mem_d;

    logic req_sync, full, empty, push, pop;

    always_comb begin
        req_sync = sync_q[SYNC_STAGES-1];
        full     = (cnt_q == CNT_W'(DEPTH));
        empty    = (cnt_q == '0);
        // Full is judged on the registered count only; a pop this edge frees
        // the slot for the following edge.
        push     = (req_sync != ack_q) && !full;
        pop      = !empty && out_ready;

        sync_d   = {sync_q[SYNC_STAGES-2:0], in_req};
        ack_d    = push ? ~ack_q : ack_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        hold_d   = pop  ? mem_q[rd_ptr_q] : hold_q;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = in_data;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            hold_q   <= '0;
            mem_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            mem_q    <= mem_d;
        end
    end

    // When empty, out_data keeps showing the last token handed out.
    assign out_data   = empty ? hold_q : mem_q[rd_ptr_q];
    assign out_valid  = !empty;
    assign fill_level = cnt_q;
    assign in_ack     = ack_q;

endmodule

// File: tb/tb_click_to_sync_bridge.sv
// Bench for click_to_sync_bridge: table of single-token vectors, hand-written
// backpressure/full/reset sequences, and a queue scoreboard on the output side.
module tb_click_to_sync_bridge;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;

    logic              clk;
    logic              rst_n;
    logic              in_req;
    logic [DATA_W-1:0] in_data;
    logic              in_ack;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        fill_level;

    click_to_sync_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .fill_level(fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output scoreboard: every accepted token must match the oldest expected one.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("fill_range", {31'd0, fill_level > 3'(DEPTH)}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_extra: got 0x%0h expected no token at %0t", out_data, $time);
                end else begin
                    check("sb_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        exp_q.push_back(d);
        in_data = d;
        in_req  = ~in_req;
    endtask

    task automatic wait_ack(input int maxe, output int n);
        n = 0;
        while (in_ack != in_req && n < maxe) begin
            tick();
            n++;
        end
    endtask

    task automatic drain(input int maxe);
        int n;
        n = 0;
        while (fill_level != 0 && n < maxe) begin
            tick();
            n++;
        end
        check("drain_fill", {29'd0, fill_level}, 32'd0);
    endtask

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] late_data;
        logic [DATA_W-1:0] exp_out;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int n;
        vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
        vecs[1] = '{8'h3C, 8'hFF, 8'h3C};
        vecs[2] = '{8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 8'hFF};

        rst_n = 1'b0; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_fill",  {29'd0, fill_level}, 32'd0);
        check("rst_ack",   {31'd0, in_ack}, 32'd0);
        check("rst_data",  {24'd0, out_data}, 32'd0);
        #20 rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // Single tokens with ready high; data changes once ack has returned.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data);
            wait_ack(20, n);
            check("t1_ack_lat", n, SYNC + 1);
            check("t1_valid", {31'd0, out_valid}, 32'd1);
            check("t1_out", {24'd0, out_data}, {24'd0, vecs[i].exp_out});
            in_data = vecs[i].late_data;
            tick();
            check("t1_valid_after", {31'd0, out_valid}, 32'd0);
            check("t1_fill_after", {29'd0, fill_level}, 32'd0);
            check("t1_hold", {24'd0, out_data}, {24'd0, vecs[i].exp_out});
        end
        check("t1_sb_empty", exp_q.size(), 0);

        // Backpressure: four tokens fit, the fifth stalls until a pop.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(8'(i));
            wait_ack(10, n);
            check("t2_acked", {31'd0, in_ack == in_req}, {31'd0, i <= 4});
        end
        check("t2_full", {29'd0, fill_level}, 32'd4);
        out_ready = 1'b1;
        wait_ack(20, n);
        check("t2_fifth_ack", {31'd0, in_ack == in_req}, 32'd1);
        drain(30);
        check("t2_sb_empty", exp_q.size(), 0);

        // Full with a single-cycle pop: capture lands one edge after the pop.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h10 + 8'(i));
            wait_ack(10, n);
        end
        send(8'h14);
        repeat (6) tick();
        check("t4_full", {29'd0, fill_level}, 32'd4);
        check("t4_stalled", {31'd0, in_ack == in_req}, 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t4_fill_pop", {29'd0, fill_level}, 32'd3);
        check("t4_no_ack_yet", {31'd0, in_ack == in_req}, 32'd0);
        tick();
        check("t4_fill_refill", {29'd0, fill_level}, 32'd4);
        check("t4_ack", {31'd0, in_ack == in_req}, 32'd1);
        out_ready = 1'b1;
        drain(30);
        check("t4_sb_empty", exp_q.size(), 0);

        // Random streaming with random backpressure.
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    send(8'($urandom));
                    wait_ack(200, n);
                    check("t3_ack", {31'd0, in_ack == in_req}, 32'd1);
                end
            end
            begin
                repeat (400) begin
                    tick();
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain(40);
        check("t3_sb_empty", exp_q.size(), 0);

        // Asynchronous reset between edges with three entries stored.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(8'h50 + 8'(i));
            wait_ack(10, n);
        end
        check("t5_fill_pre", {29'd0, fill_level}, 32'd3);
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        in_req = 1'b0;
        #1;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_fill",  {29'd0, fill_level}, 32'd0);
        check("t5_ack",   {31'd0, in_ack}, 32'd0);
        exp_q.delete();
        #13 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        check("t5_no_token", {31'd0, out_valid}, 32'd0);
        check("t5_ack_post", {31'd0, in_ack}, 32'd0);
        check("t5_fill_post", {29'd0, fill_level}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
